// File: rtl/rx_len_typ_pkg.sv
// Shared constants and types for the rx length/type parser.
package rx_len_typ_pkg;

  localparam logic [15:0] TPID_CTAG         = 16'h8100;
  localparam logic [15:0] TPID_STAG         = 16'h88A8;
  localparam logic [15:0] TYPE_PAUSE        = 16'h8808;
  localparam logic [15:0] LEN_TYPE_BOUNDARY = 16'h0600;
  localparam logic [15:0] LEN_RSVD_LO       = 16'h05DD;
  localparam logic [15:0] LEN_RSVD_HI       = 16'h05FF;

  localparam logic [15:0] HDR_LEN_UNTAG = 16'd14;
  localparam logic [15:0] HDR_FCS_LEN   = 16'd18;
  localparam logic [15:0] MIN_PAY_UNTAG = 16'd46;
  localparam logic [15:0] MIN_PAY_TAG   = 16'd42;

  typedef enum logic {IDLE = 1'b0, INFRM = 1'b1} state_t;

  function automatic logic is_tpid(input logic [15:0] v);
    return (v == TPID_CTAG) || (v == TPID_STAG);
  endfunction

endpackage

// File: rtl/rx_len_typ_parser_capture.sv
// Beat-index counter and Length/Type candidate capture behind up to MAX_TAGS VLAN tags.
module rx_hdr_field_capture
  import rx_len_typ_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int MAX_TAGS   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    beat,
  input  logic                    sof,
  input  logic [8*DATA_BYTES-1:0] data,
  output logic [15:0]             cand_nx [MAX_TAGS+1]
);

  localparam int BASE      = int'(HDR_LEN_UNTAG) - 2;
  localparam int LAST_BEAT = (BASE + 4*MAX_TAGS) / DATA_BYTES;
  localparam int IDX_W     = $clog2(LAST_BEAT + 2);

  logic [IDX_W-1:0] idx, idx_cur;
  logic [15:0]      cand [MAX_TAGS+1];
  logic             unused_lanes;

  assign idx_cur      = sof ? '0 : idx;
  assign unused_lanes = ^data;

  // Stage p0: candidate view including the current beat, so eof-beat captures resolve in time
  always_comb begin
    for (int i = 0; i <= MAX_TAGS; i++) begin
      cand_nx[i] = sof ? 16'h0000 : cand[i];
      if (beat && (idx_cur == IDX_W'((BASE + 4*i) / DATA_BYTES)))
        cand_nx[i] = {data[8*((BASE + 4*i) % DATA_BYTES) +: 8],
                      data[8*((BASE + 4*i) % DATA_BYTES + 1) +: 8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      for (int i = 0; i <= MAX_TAGS; i++) cand[i] <= 16'h0000;
    end else if (beat) begin
      idx <= (idx_cur > IDX_W'(LAST_BEAT)) ? idx_cur : idx_cur + 1'b1;
      for (int i = 0; i <= MAX_TAGS; i++) cand[i] <= cand_nx[i];
    end
  end

endmodule

// File: rtl/rx_len_typ_parser.sv
// Per-frame length/type parser: byte count, VLAN-tag walk, size and length-field checks.
// Optional Length-field consistency check enabled by defining RX_LEN_FIELD_CHECK_EN.
module rx_len_typ_parser
  import rx_len_typ_pkg::*;
#(
  parameter int DATA_BYTES    = 8,
  parameter int MAX_TAGS      = 2,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_STD_LEN   = 1518,
  parameter int MAX_JUMBO_LEN = 9018
) (
  input  logic                              rxclk,
  input  logic                              reset_n,
  input  logic                              jumbo_enable,
  input  logic                              vlan_enable,
  input  logic                              rx_valid,
  input  logic                              rx_sof,
  input  logic                              rx_eof,
  input  logic [$clog2(DATA_BYTES+1)-1:0]   rx_eof_bytes,
  input  logic [8*DATA_BYTES-1:0]           rx_data,
  output logic                              result_valid,
  output logic [15:0]                       frame_len,
  output logic [15:0]                       len_typ,
  output logic [1:0]                        tag_count,
  output logic                              is_pause,
  output logic                              pad_present,
  output logic                              undersize_error,
  output logic                              length_error,
  output logic                              len_mismatch_error
);

  state_t      state, state_nx;
  logic        sof_beat, in_frame_beat, frame_end;
  logic [15:0] byte_cnt, byte_cnt_nx;
  logic [15:0] cand_nx [MAX_TAGS+1];

  logic        walking, ovf_p0, mismatch_p0;
  logic [1:0]  tc_p0;
  logic [15:0] lt_p0, limit_p0, minpay_p0;

  logic        vld_p1, pause_p1, pad_p1, under_p1, lerr_p1, mm_p1;
  logic [1:0]  tc_p1;
  logic [15:0] len_p1, lt_p1;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign sof_beat      = rx_valid & rx_sof;
  assign in_frame_beat = sof_beat | (rx_valid & (state == INFRM));
  assign frame_end     = in_frame_beat & rx_eof;
  assign byte_cnt_nx   = sat_add16(sof_beat ? 16'h0000 : byte_cnt,
                                   rx_eof ? 16'(rx_eof_bytes) : 16'(DATA_BYTES));

  rx_hdr_field_capture #(
    .DATA_BYTES (DATA_BYTES),
    .MAX_TAGS   (MAX_TAGS)
  ) u_capture (
    .clk     (rxclk),
    .rst_n   (reset_n),
    .beat    (in_frame_beat),
    .sof     (sof_beat),
    .data    (rx_data),
    .cand_nx (cand_nx)
  );

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      byte_cnt <= 16'h0000;
    end else begin
      state <= state_nx;
      if (in_frame_beat) byte_cnt <= byte_cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (rx_valid) begin
      if (rx_sof)      state_nx = rx_eof ? IDLE : INFRM;
      else if (rx_eof) state_nx = IDLE;
    end
  end

  // Stage p0: tag walk and frame checks, evaluated on the eof beat
  always_comb begin
    walking = vlan_enable;
    tc_p0   = 2'd0;
    lt_p0   = cand_nx[0];
    for (int i = 0; i < MAX_TAGS; i++) begin
      if (walking && is_tpid(cand_nx[i])) begin
        tc_p0 = tc_p0 + 2'd1;
        lt_p0 = cand_nx[i+1];
      end else begin
        walking = 1'b0;
      end
    end
    ovf_p0    = walking & is_tpid(cand_nx[MAX_TAGS]);
    limit_p0  = (jumbo_enable ? 16'(MAX_JUMBO_LEN) : 16'(MAX_STD_LEN)) + {12'h000, tc_p0, 2'b00};
    minpay_p0 = (tc_p0 == 2'd0) ? MIN_PAY_UNTAG : MIN_PAY_TAG;
  end

`ifdef RX_LEN_FIELD_CHECK_EN
  logic [15:0] hdr_p0, payload_p0;
  logic        field_bad_p0;

  always_comb begin
    hdr_p0       = HDR_FCS_LEN + {12'h000, tc_p0, 2'b00};
    payload_p0   = (byte_cnt_nx > hdr_p0) ? byte_cnt_nx - hdr_p0 : 16'h0000;
    field_bad_p0 = ((lt_p0 < LEN_TYPE_BOUNDARY) &&
                    ((lt_p0 > payload_p0) || ((lt_p0 != payload_p0) && (payload_p0 > minpay_p0)))) ||
                   ((lt_p0 >= LEN_RSVD_LO) && (lt_p0 <= LEN_RSVD_HI));
  end

  assign mismatch_p0 = ovf_p0 | field_bad_p0;
`else
  assign mismatch_p0 = ovf_p0;
`endif

  // Stage p1: registered result, held until the next frame completes
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      len_p1   <= 16'h0000;
      lt_p1    <= 16'h0000;
      tc_p1    <= 2'd0;
      pause_p1 <= 1'b0;
      pad_p1   <= 1'b0;
      under_p1 <= 1'b0;
      lerr_p1  <= 1'b0;
      mm_p1    <= 1'b0;
    end else begin
      vld_p1 <= frame_end;
      if (frame_end) begin
        len_p1   <= byte_cnt_nx;
        lt_p1    <= lt_p0;
        tc_p1    <= tc_p0;
        pause_p1 <= (lt_p0 == TYPE_PAUSE);
        pad_p1   <= (lt_p0 < LEN_TYPE_BOUNDARY) && (lt_p0 < minpay_p0);
        under_p1 <= (byte_cnt_nx < 16'(MIN_FRAME_LEN));
        lerr_p1  <= (byte_cnt_nx > limit_p0);
        mm_p1    <= mismatch_p0;
      end
    end
  end

  assign result_valid       = vld_p1;
  assign frame_len          = len_p1;
  assign len_typ            = lt_p1;
  assign tag_count          = tc_p1;
  assign is_pause           = pause_p1;
  assign pad_present        = pad_p1;
  assign undersize_error    = under_p1;
  assign length_error       = lerr_p1;
  assign len_mismatch_error = mm_p1;

endmodule

// File: tb/tb_rx_len_typ_parser.sv
// Directed bench for rx_len_typ_parser: byte-level frame model plus hand-computed literal checks.
module tb_rx_len_typ_parser;

  localparam int DB = 8;
  localparam int MT = 2;
`ifdef RX_LEN_FIELD_CHECK_EN
  localparam bit MM_ON = 1'b1;
`else
  localparam bit MM_ON = 1'b0;
`endif

  logic        rxclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        jumbo_enable = 1'b0, vlan_enable = 1'b0;
  logic        rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
  logic [3:0]  rx_eof_bytes = 4'd0;
  logic [63:0] rx_data = 64'h0;
  logic        result_valid, is_pause, pad_present, undersize_error, length_error, len_mismatch_error;
  logic [15:0] frame_len, len_typ;
  logic [1:0]  tag_count;

  rx_len_typ_parser dut (
    .rxclk(rxclk), .reset_n(reset_n), .jumbo_enable(jumbo_enable), .vlan_enable(vlan_enable),
    .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_eof_bytes(rx_eof_bytes),
    .rx_data(rx_data), .result_valid(result_valid), .frame_len(frame_len), .len_typ(len_typ),
    .tag_count(tag_count), .is_pause(is_pause), .pad_present(pad_present),
    .undersize_error(undersize_error), .length_error(length_error),
    .len_mismatch_error(len_mismatch_error)
  );

  always #5 rxclk = ~rxclk;

  typedef struct {
    int len; int lt; int tc;
    bit pause; bit pad; bit under; bit lerr; bit mm;
  } exp_t;

  int          checks = 0, failures = 0;
  exp_t        expq[$];
  logic [7:0]  frm[$];
  exp_t        got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic bit tag(input int v);
    return (v == 16'h8100) || (v == 16'h88A8);
  endfunction

  // Expected result derived straight from the frame bytes.
  function automatic exp_t model(input bit jumbo, input bit vlan);
    exp_t e;
    int   n, i, minpay, payload;
    int   cand[MT+1];
    n = frm.size();
    for (int k = 0; k <= MT; k++)
      cand[k] = (12 + 4*k + 1 < n) ? {frm[12+4*k], frm[13+4*k]} : 0;
    i = 0;
    while (vlan && i < MT && tag(cand[i])) i++;
    e.tc     = i;
    e.lt     = cand[i];
    e.len    = n;
    e.lerr   = n > ((jumbo ? 9018 : 1518) + 4*i);
    e.under  = n < 64;
    e.pause  = e.lt == 16'h8808;
    minpay   = (i == 0) ? 46 : 42;
    e.pad    = (e.lt < 1536) && (e.lt < minpay);
    e.mm     = vlan && (i == MT) && tag(cand[MT]);
    payload  = n - 18 - 4*i;
    if (payload < 0) payload = 0;
    if (MM_ON && (e.lt < 1536) && ((e.lt > payload) || ((e.lt != payload) && (payload > minpay)))) e.mm = 1'b1;
    if (MM_ON && (e.lt >= 16'h05DD) && (e.lt <= 16'h05FF)) e.mm = 1'b1;
    return e;
  endfunction

  task automatic make(input int n, input int w0, input int w1, input int w2);
    frm.delete();
    for (int b = 0; b < n; b++) frm.push_back(8'(b*7 + 3));
    frm[12] = 8'(w0 >> 8); frm[13] = 8'(w0);
    if (w1 >= 0) begin frm[16] = 8'(w1 >> 8); frm[17] = 8'(w1); end
    if (w2 >= 0) begin frm[20] = 8'(w2 >> 8); frm[21] = 8'(w2); end
  endtask

  // Drives the frame in frm; stop_at>=0 cuts it short (no result), gap_at inserts an idle beat.
  task automatic send(input bit jumbo, input bit vlan, input int stop_at, input int gap_at);
    int n, beats;
    n = frm.size();
    beats = (n + DB - 1) / DB;
    jumbo_enable = jumbo;
    vlan_enable  = vlan;
    for (int b = 0; b < beats; b++) begin
      if (stop_at >= 0 && b == stop_at) break;
      if (b == gap_at) begin
        rx_valid = 1'b0; rx_sof = 1'b1; rx_eof = 1'b1; rx_eof_bytes = 4'd3;
        rx_data = {$urandom, $urandom};
        @(posedge rxclk); #1;
      end
      rx_valid = 1'b1;
      rx_sof   = (b == 0);
      rx_eof   = (b == beats - 1);
      rx_eof_bytes = rx_eof ? 4'(n - b*DB) : 4'd0;
      for (int l = 0; l < DB; l++) rx_data[8*l +: 8] = (b*DB + l < n) ? frm[b*DB + l] : 8'h00;
      if (rx_eof) expq.push_back(model(jumbo, vlan));
      @(posedge rxclk); #1;
    end
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge rxclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag_s);
    check({tag_s, "_vld"}, result_valid, 0);
    check({tag_s, "_len"}, frame_len, 0);
    check({tag_s, "_lt"}, len_typ, 0);
    check({tag_s, "_flags"}, {tag_count, is_pause, pad_present, undersize_error, length_error, len_mismatch_error}, 0);
  endtask

  // Every result pulse must match the next modelled frame; any unexpected pulse is a failure.
  always @(posedge rxclk) begin
    #2;
    if (reset_n && result_valid) begin
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result: got result_valid=1 expected 0 (len=%0d)", frame_len);
      end else begin
        got = expq.pop_front();
        check("m_len",   frame_len, got.len);
        check("m_lt",    len_typ, got.lt);
        check("m_tc",    tag_count, got.tc);
        check("m_pause", is_pause, got.pause);
        check("m_pad",   pad_present, got.pad);
        check("m_under", undersize_error, got.under);
        check("m_lerr",  length_error, got.lerr);
        check("m_mm",    len_mismatch_error, got.mm);
      end
    end
  end

  initial begin
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge rxclk);
    #1 reset_n = 1'b1;

    make(64, 16'h0800, -1, -1);           send(1'b0, 1'b1, -1, -1);
    check("t1_vld_pulse", result_valid, 1);
    settle();
    check("t1_len", frame_len, 64);
    check("t1_tc", tag_count, 0);
    check("t1_flags", {undersize_error, length_error, len_mismatch_error, pad_present, is_pause}, 0);
    check("t1_vld_low", result_valid, 0);

    make(1519, 16'h0800, -1, -1);         send(1'b0, 1'b0, -1, -1); settle();
    check("t2_lerr_std", length_error, 1);
    send(1'b1, 1'b0, -1, -1); settle();
    check("t2_lerr_jumbo", length_error, 0);

    make(1526, 16'h8100, 16'h88A8, 16'h0800);
    send(1'b0, 1'b1, -1, -1); settle();
    check("t3_tc2", tag_count, 2);
    check("t3_lt", len_typ, 16'h0800);
    check("t3_lerr_tagged", length_error, 0);
    send(1'b0, 1'b0, -1, -1); settle();
    check("t3_lt_novlan", len_typ, 16'h8100);
    check("t3_lerr_novlan", length_error, 1);

    make(64, 16'h0010, -1, -1);           send(1'b0, 1'b0, -1, -1); settle();
    check("t4_pad", pad_present, 1);
    check("t4_mm_ok", len_mismatch_error, 0);
    make(64, 16'h0100, -1, -1);           send(1'b0, 1'b0, -1, -1); settle();
    check("t4_mm_long", len_mismatch_error, MM_ON);
    make(64, 16'h05E0, -1, -1);           send(1'b0, 1'b0, -1, -1); settle();
    check("t4_mm_rsvd", len_mismatch_error, MM_ON);

    make(64, 16'h8808, -1, -1);           send(1'b0, 1'b1, -1, 3); settle();
    check("t5_pause", is_pause, 1);
    make(60, 16'h0800, -1, -1);           send(1'b0, 1'b0, -1, -1); settle();
    check("t5_under", undersize_error, 1);
    check("t5_len60", frame_len, 60);

    make(80, 16'h8100, 16'h8100, 16'h8100); send(1'b1, 1'b1, -1, -1); settle();
    check("tag_overflow", len_mismatch_error, 1);

    // Stray eof while idle must be ignored.
    rx_valid = 1'b1; rx_eof = 1'b1; rx_eof_bytes = 4'd8;
    @(posedge rxclk); #1;
    rx_valid = 1'b0; rx_eof = 1'b0;
    settle();

    make(128, 16'h0800, -1, -1);          send(1'b0, 1'b0, 3, -1);
    make(64, 16'h0806, -1, -1);           send(1'b0, 1'b0, -1, -1); settle();
    check("t6_restart_len", frame_len, 64);
    check("t6_restart_lt", len_typ, 16'h0806);

    make(128, 16'h0800, -1, -1);          send(1'b0, 1'b0, 4, -1);
    reset_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    repeat (2) @(posedge rxclk);
    #1 reset_n = 1'b1;
    settle();
    check("t6_after_reset_vld", result_valid, 0);
    make(72, 16'h0800, -1, -1);           send(1'b0, 1'b0, -1, -1); settle();
    check("t6_after_reset_len", frame_len, 72);

    repeat (5) @(posedge rxclk);
    #3;
    check("drain_pending", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
